// File: rtl/dm_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the data-memory controller.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dm_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Half-words need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic dm_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic dm_illegal(input logic we, input logic [2:0] funct3);
        logic ill;
        if (we) begin
            ill = (funct3 > F3_W);
        end else begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ill = 1'b0;
                default:                        ill = 1'b1;
            endcase
        end
        return ill;
    endfunction

endpackage

// File: rtl/dm_if.sv
// Request/response handshake bundle between the MEM stage (master) and dm_ctrl (slave).
interface dm_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_bank.sv
// Single-port word array with per-byte write enables and a registered read port.
module dm_bank #(
    parameter int DEPTH_W = 7,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [DEPTH_W-1:0] idx_i,
    input  logic [DATA_W-1:0]  wdata_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Byte-enabled write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read; the data register holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_ctrl.sv
// Handshaked RV32 data-memory controller: alignment, extension, byte enables and wait states.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst_n,
    dm_if.slave  bus
);

    localparam int         IDX_W = DM_ADDRESS - 2;
    localparam logic [2:0] WS_L  = 3'(WAIT_STATES);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("dm_ctrl: DATA_W must be 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait
        $error("dm_ctrl: WAIT_STATES must be 0..7");
    end

    dm_state_e             state_q, state_d;
    logic [2:0]            wcnt_q, wcnt_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  bank_en_s;
    logic                  bank_we_s;
    logic [3:0]            bank_be_s;
    logic [DATA_W-1:0]     bank_wdata_s;
    logic [DATA_W-1:0]     bank_rdata_s;
    logic [DATA_W-1:0]     load_data_s;
    logic [7:0]            byte_s;
    logic [15:0]           half_s;

    dm_bank #(
        .DEPTH_W (IDX_W),
        .DATA_W  (DATA_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (bank_en_s),
        .we_i    (bank_we_s),
        .be_i    (bank_be_s),
        .idx_i   (addr_q[DM_ADDRESS-1:2]),
        .wdata_i (bank_wdata_s),
        .rdata_o (bank_rdata_s)
    );

    // State, captured request and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= 3'd0;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= {DM_ADDRESS{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DATA_W{1'b0}};
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next state; the response registers load one cycle into RESP, once read data is settled.
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        bank_en_s    = 1'b0;
        bank_we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    f3_d        = bus.req_funct3;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    err_d       = dm_misaligned(bus.req_funct3, bus.req_addr[1:0]) |
                                  dm_illegal(bus.req_we, bus.req_funct3);
                    wcnt_d      = 3'd0;
                    req_ready_d = 1'b0;
                    state_d     = (WS_L != 3'd0) ? WAIT : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q + 3'd1;
                if (wcnt_q + 3'd1 == WS_L) begin
                    state_d = ACCESS;
                end else begin
                    state_d = WAIT;
                end
            end
            ACCESS: begin
                // Erroneous requests never touch the array.
                bank_en_s = ~err_q;
                bank_we_s = we_q & ~err_q;
                state_d   = RESP;
            end
            RESP: begin
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    resp_rdata_d = (we_q || err_q) ? {DATA_W{1'b0}} : load_data_s;
                end else if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = {DATA_W{1'b0}};
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = {DATA_W{1'b0}};
            end
        endcase
    end

    // Store lane steering: byte enables plus data replicated across the lanes.
    always_comb begin
        bank_be_s    = 4'b0000;
        bank_wdata_s = wdata_q;
        case (f3_q)
            F3_B: begin
                bank_be_s    = 4'b0001 << addr_q[1:0];
                bank_wdata_s = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                bank_be_s    = addr_q[1] ? 4'b1100 : 4'b0011;
                bank_wdata_s = {2{wdata_q[15:0]}};
            end
            F3_W: begin
                bank_be_s = 4'b1111;
            end
            default: begin
                bank_be_s = 4'b0000;
            end
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        byte_s = bank_rdata_s[{addr_q[1:0], 3'b000} +: 8];
        half_s = addr_q[1] ? bank_rdata_s[31:16] : bank_rdata_s[15:0];
        case (f3_q)
            F3_B:    load_data_s = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data_s = {{16{half_s[15]}}, half_s};
            F3_W:    load_data_s = bank_rdata_s;
            F3_BU:   load_data_s = {24'd0, byte_s};
            F3_HU:   load_data_s = {16'd0, half_s};
            default: load_data_s = {DATA_W{1'b0}};
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: instance 0 has no wait states, instance 1 has three.
module tb_dm_ctrl;
    import dm_pkg::*;

    localparam int LAT0 = 2;
    localparam int LAT1 = 5;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sbq[$];

    logic        rv    [2];
    logic        rwe   [2];
    logic [2:0]  rf3   [2];
    logic [8:0]  ra    [2];
    logic [31:0] rwd   [2];
    logic        rrdy_o[2];
    logic        rready[2];
    logic        rvalid[2];
    logic [31:0] rdat  [2];
    logic        rerr  [2];
    logic        pvalid[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_if #(.DM_ADDRESS(9), .DATA_W(32)) b0 ();
    dm_if #(.DM_ADDRESS(9), .DATA_W(32)) b1 ();

    assign b0.req_valid = rv[0];  assign b1.req_valid = rv[1];
    assign b0.req_we = rwe[0];    assign b1.req_we = rwe[1];
    assign b0.req_funct3 = rf3[0]; assign b1.req_funct3 = rf3[1];
    assign b0.req_addr = ra[0];   assign b1.req_addr = ra[1];
    assign b0.req_wdata = rwd[0]; assign b1.req_wdata = rwd[1];
    assign b0.resp_ready = rready[0]; assign b1.resp_ready = rready[1];
    assign rrdy_o[0] = b0.req_ready;  assign rrdy_o[1] = b1.req_ready;
    assign rvalid[0] = b0.resp_valid; assign rvalid[1] = b1.resp_valid;
    assign rdat[0] = b0.resp_rdata;   assign rdat[1] = b1.resp_rdata;
    assign rerr[0] = b0.resp_err;     assign rerr[1] = b1.resp_err;

    dm_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    dm_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!rrdy_o[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rrdy_o[i]) chk("req_ready_timeout", 32'(rrdy_o[i]), 32'd1);
    endtask

    // Drive one request; the expected response is queued at the acceptance edge.
    task automatic issue(input int i, input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee, input bit push);
        @(negedge clk);
        wait_ready(i);
        rv[i] = 1'b1; rwe[i] = we; rf3[i] = f3; ra[i] = addr; rwd[i] = wd;
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
        chk("req_ready_drop", 32'(rrdy_o[i]), 32'd0);
        if (push) sbq.push_back('{i, er, ee, cyc});
    endtask

    // Monitor: checks every presented response; pops on the handshake cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rvalid[i] && rst_n) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 32'(rvalid[i]), 32'd0);
                end else begin
                    e = sbq[0];
                    if (!pvalid[i]) chk("latency", 32'(cyc - e.acc), 32'((i == 0) ? LAT0 : LAT1));
                    chk("resp_inst", 32'(i), 32'(e.inst));
                    chk("resp_rdata", rdat[i], e.rdata);
                    chk("resp_err", 32'(rerr[i]), 32'(e.err));
                    chk("ready_while_busy", 32'(rrdy_o[i]), 32'd0);
                    if (rready[i]) void'(sbq.pop_front());
                end
            end
            pvalid[i] = rvalid[i] && rst_n;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rwe[i] = 1'b0; rf3[i] = 3'd0; ra[i] = 9'd0; rwd[i] = 32'd0;
            rready[i] = 1'b1; pvalid[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_req_ready", 32'(rrdy_o[i]), 32'd1);
            chk("reset_resp_valid", 32'(rvalid[i]), 32'd0);
            chk("reset_resp_rdata", rdat[i], 32'd0);
            chk("reset_resp_err", 32'(rerr[i]), 32'd0);
        end
        rst_n = 1'b1;

        // No wait states: store/load round trip and lane handling.
        issue(0, 1'b1, F3_W,  9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1);
        issue(0, 1'b0, F3_W,  9'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
        issue(0, 1'b1, F3_W,  9'h020, 32'h11223344, 32'h00000000, 1'b0, 1'b1);
        issue(0, 1'b1, F3_B,  9'h021, 32'h000000AA, 32'h00000000, 1'b0, 1'b1);
        issue(0, 1'b0, F3_W,  9'h020, 32'h0,        32'h1122AA44, 1'b0, 1'b1);
        issue(0, 1'b0, F3_B,  9'h021, 32'h0,        32'hFFFFFFAA, 1'b0, 1'b1);
        issue(0, 1'b0, F3_BU, 9'h021, 32'h0,        32'h000000AA, 1'b0, 1'b1);
        issue(0, 1'b1, F3_H,  9'h032, 32'h00008001, 32'h00000000, 1'b0, 1'b1);
        issue(0, 1'b0, F3_H,  9'h032, 32'h0,        32'hFFFF8001, 1'b0, 1'b1);
        issue(0, 1'b0, F3_HU, 9'h032, 32'h0,        32'h00008001, 1'b0, 1'b1);
        issue(0, 1'b0, F3_H,  9'h031, 32'h0,        32'h00000000, 1'b1, 1'b1);
        issue(0, 1'b1, F3_W,  9'h040, 32'h55AA55AA, 32'h00000000, 1'b0, 1'b1);
        issue(0, 1'b1, F3_W,  9'h041, 32'h12345678, 32'h00000000, 1'b1, 1'b1);
        issue(0, 1'b0, F3_W,  9'h040, 32'h0,        32'h55AA55AA, 1'b0, 1'b1);
        issue(0, 1'b0, 3'b011, 9'h040, 32'h0,       32'h00000000, 1'b1, 1'b1);
        issue(0, 1'b1, 3'b100, 9'h040, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
        issue(0, 1'b1, F3_B,  9'h043, 32'h00000077, 32'h00000000, 1'b0, 1'b1);
        issue(0, 1'b0, F3_W,  9'h040, 32'h0,        32'h77AA55AA, 1'b0, 1'b1);
        issue(0, 1'b0, F3_H,  9'h042, 32'h0,        32'h000077AA, 1'b0, 1'b1);
        issue(0, 1'b0, F3_B,  9'h040, 32'h0,        32'hFFFFFFAA, 1'b0, 1'b1);
        issue(0, 1'b0, F3_B,  9'h041, 32'h0,        32'h00000055, 1'b0, 1'b1);

        // Three wait states, response held off by the consumer.
        issue(1, 1'b1, F3_W,  9'h050, 32'h0BADC0DE, 32'h00000000, 1'b0, 1'b1);
        @(negedge clk);
        wait_ready(1);
        rready[1] = 1'b0;
        issue(1, 1'b0, F3_W,  9'h050, 32'h0,        32'h0BADC0DE, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        rready[1] = 1'b1;

        // Reset while the store sits in WAIT: no write, outputs back to reset values.
        issue(1, 1'b1, F3_W,  9'h050, 32'hCAFEF00D, 32'h00000000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("wait_rst_req_ready", 32'(rrdy_o[1]), 32'd1);
        chk("wait_rst_resp_valid", 32'(rvalid[1]), 32'd0);
        chk("wait_rst_resp_rdata", rdat[1], 32'd0);
        chk("wait_rst_resp_err", 32'(rerr[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1, 1'b0, F3_W,  9'h050, 32'h0,        32'h0BADC0DE, 1'b0, 1'b1);
        issue(1, 1'b0, F3_HU, 9'h052, 32'h0,        32'h00000BAD, 1'b0, 1'b1);

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
